// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the instruction sequencer
package seq_pkg;
    localparam int IW_DEF = 16;
    localparam logic [15:0] HALT_WORD_DEF = 16'hFFFF;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALTED} seq_state_t;

    function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [15:0] w);
        return w[OPC_MSB:OPC_LSB];
    endfunction
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: DEPTH x IW instruction buffer with occupancy count and synchronous flush
module instr_fifo #(
    parameter int IW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   wr_en,
    input  logic [IW-1:0]          wr_data,
    input  logic                   rd_en,
    input  logic                   flush,
    output logic [IW-1:0]          rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [IW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic          w_wr, w_rd;

    // flush wins over a simultaneous write; a pop in the flush cycle still sees the old head
    assign w_wr    = wr_en && r_cnt != (AW+1)'(DEPTH) && !flush;
    assign w_rd    = rd_en && r_cnt != '0;
    assign rd_data = r_mem[r_rp];
    assign count   = r_cnt;
    assign empty   = r_cnt == '0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn || flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            r_wp  <= r_wp + AW'(w_wr);
            r_rp  <= r_rp + AW'(w_rd);
            r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wp] <= wr_data;
    end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: buffers loader instructions and issues them one at a time to processador.
// Defining ISSUE_COUNT_EN adds the issue_cnt and halt_seen outputs.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int            IW        = IW_DEF,
    parameter int            DEPTH     = 8,
    parameter logic [IW-1:0] HALT_WORD = IW'(HALT_WORD_DEF)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          in_valid,
    input  logic [IW-1:0] in_data,
    output logic          in_ready,
    input  logic          flush,
    input  logic          resume,
    output logic [IW-1:0] iin,
    output logic          run,
    input  logic          done,
    output logic          halted,
    output logic          busy
`ifdef ISSUE_COUNT_EN
    ,
    output logic [15:0]   issue_cnt,
    output logic          halt_seen
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    seq_state_t    r_state, w_next;
    logic [IW-1:0] r_iin, w_head;
    logic [CW-1:0] w_count;
    logic          w_empty, w_pop, w_is_halt;

    instr_fifo #(.IW(IW), .DEPTH(DEPTH)) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .wr_en  (in_valid),
        .wr_data(in_data),
        .rd_en  (w_pop),
        .flush  (flush),
        .rd_data(w_head),
        .count  (w_count),
        .empty  (w_empty)
    );

    always_comb begin
        w_is_halt = w_head == HALT_WORD;
        w_pop     = !w_empty && (r_state == IDLE || (r_state == WAIT && done));
        w_next    = w_pop                         ? (w_is_halt ? HALTED : ISSUE) :
                    r_state == ISSUE              ? WAIT :
                    r_state == WAIT && done       ? IDLE :
                    r_state == HALTED && resume   ? IDLE : r_state;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // the HALT word is consumed but never presented on iin
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                  r_iin <= '0;
        else if (w_pop && !w_is_halt) r_iin <= w_head;
    end

    assign iin      = r_iin;
    assign run      = r_state == ISSUE;
    assign busy     = r_state == ISSUE || r_state == WAIT;
    assign halted   = r_state == HALTED;
    assign in_ready = w_count != CW'(DEPTH);

`ifdef ISSUE_COUNT_EN
    logic [15:0] r_issue_cnt;
    logic        r_halt_seen;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_issue_cnt <= '0;
            r_halt_seen <= 1'b0;
        end else begin
            if (r_state == ISSUE) r_issue_cnt <= r_issue_cnt + 16'd1;
            if (w_pop && w_is_halt) r_halt_seen <= 1'b1;
            else if (resume)        r_halt_seen <= 1'b0;
        end
    end

    assign issue_cnt = r_issue_cnt;
    assign halt_seen = r_halt_seen;
`endif
endmodule
